ser_slot_arbiter: RTL and testbench

SER_SLOT_ARBITER -- requirements
Module: ser_slot_arbiter

---
 rtl/ser_slot_arbiter.sv | 122 ++++++++++++
 tb/tb_ser_slot_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ser_slot_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ser_slot_arbiter
// Description : Round-robin slot arbiter feeding one word per FROM-cycle slot
//               into a serializer's parallel input, with idle fill and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module ser_slot_arbiter #(
    parameter int              FROM      = 2,
    parameter int              LOGFROM   = 1,
    parameter int              NREQ      = 4,
    parameter int              LOGNREQ   = 2,
    parameter logic [FROM-1:0] IDLE_WORD = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en_i,
    input  logic [NREQ-1:0]        req_valid_i,
    input  logic [NREQ*FROM-1:0]   req_data_i,
    output logic [NREQ-1:0]        req_ready_o,
    output logic [FROM-1:0]        data_o,
    output logic                   load_o,
    output logic [LOGNREQ-1:0]     grant_o,
    output logic                   idle_o,
    output logic                   busy_o
);

    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [LOGFROM-1:0]   cnt;
    logic [LOGNREQ-1:0]   last_grant;
    logic [LOGNREQ-1:0]   pick;
    logic [LOGNREQ-1:0]   cand;
    logic                 found;
    logic                 slot_end;
    logic                 load_cycle;

    assign slot_end   = (cnt == LOGFROM'(FROM - 1));
    assign load_cycle = (state == S_RUN) && slot_end;
    assign busy_o     = (state != S_OFF);

    // Search upward from the requester after the last winner; offset NREQ
    // wraps back to last_grant itself so a lone requester can win again.
    always_comb begin
        found = 1'b0;
        pick  = last_grant;
        cand  = last_grant;
        for (int i = 1; i <= NREQ; i++) begin
            cand = last_grant + LOGNREQ'(i);
            if (!found && req_valid_i[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (load_cycle && found && !reset) begin
            req_ready_o = NREQ'(1) << pick;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_OFF:   if (en_i) state_next = S_RUN;
            S_RUN:   if (!en_i) state_next = S_FLUSH;
            S_FLUSH: begin
                if (en_i) begin
                    state_next = S_RUN;
                end else if (slot_end) begin
                    state_next = S_OFF;
                end
            end
            default: state_next = S_OFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_OFF;
            cnt        <= '0;
            data_o     <= IDLE_WORD;
            load_o     <= 1'b0;
            idle_o     <= 1'b1;
            grant_o    <= '0;
            last_grant <= LOGNREQ'(NREQ - 1);
        end else begin
            state  <= state_next;
            cnt    <= (state == S_OFF) ? '0 : cnt + LOGFROM'(1);
            load_o <= 1'b0;
            if (state == S_OFF) begin
                data_o <= IDLE_WORD;
                idle_o <= 1'b1;
            end else if (load_cycle) begin
                load_o <= 1'b1;
                if (found) begin
                    data_o     <= req_data_i[int'(pick)*FROM +: FROM];
                    grant_o    <= pick;
                    last_grant <= pick;
                    idle_o     <= 1'b0;
                end else begin
                    data_o <= IDLE_WORD;
                    idle_o <= 1'b1;
                end
            end else if ((state == S_FLUSH) && slot_end && !en_i) begin
                // Flush ends silently: filler is parked without a strobe.
                data_o <= IDLE_WORD;
                idle_o <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ser_slot_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ser_slot_arbiter
// Description : Directed plus random bench for ser_slot_arbiter against a
//               slot-level behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ser_slot_arbiter;

    localparam int              FROM    = 4;
    localparam int              LOGFROM = 2;
    localparam int              NREQ    = 4;
    localparam int              LOGNREQ = 2;
    localparam logic [FROM-1:0] IDLE    = 4'h0;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 en_i = 1'b0;
    logic [NREQ-1:0]      req_valid_i = '0;
    logic [NREQ*FROM-1:0] req_data_i = '0;
    logic [NREQ-1:0]      req_ready_o;
    logic [FROM-1:0]      data_o;
    logic                 load_o;
    logic [LOGNREQ-1:0]   grant_o;
    logic                 idle_o;
    logic                 busy_o;

    ser_slot_arbiter #(
        .FROM      (FROM),
        .LOGFROM   (LOGFROM),
        .NREQ      (NREQ),
        .LOGNREQ   (LOGNREQ),
        .IDLE_WORD (IDLE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en_i        (en_i),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_ready_o (req_ready_o),
        .data_o      (data_o),
        .load_o      (load_o),
        .grant_o     (grant_o),
        .idle_o      (idle_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Slot-level model: running/draining flags and elapsed cycles in slot.
    bit              m_active   = 1'b0;
    bit              m_draining = 1'b0;
    int              m_tick     = 0;
    int              m_last     = NREQ - 1;
    int              m_grant    = 0;
    logic [FROM-1:0] m_data     = IDLE;
    bit              m_idle     = 1'b1;
    bit              m_load     = 1'b0;

    function automatic int pick_next();
        for (int i = 1; i <= NREQ; i++) begin
            if (req_valid_i[(m_last + i) % NREQ]) return (m_last + i) % NREQ;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        int  p;
        bit  at_end;
        p      = pick_next();
        at_end = (m_tick == FROM - 1);
        if (reset) begin
            m_active = 0; m_draining = 0; m_tick = 0; m_data = IDLE;
            m_load = 0; m_idle = 1; m_grant = 0; m_last = NREQ - 1;
        end else if (!m_active) begin
            m_data = IDLE; m_idle = 1; m_load = 0;
            if (en_i) begin m_active = 1; m_draining = 0; m_tick = 0; end
        end else begin
            m_load = 0;
            if (!m_draining && at_end) begin
                m_load = 1;
                if (p >= 0) begin
                    m_data  = req_data_i[p*FROM +: FROM];
                    m_grant = p; m_last = p; m_idle = 0;
                end else begin
                    m_data = IDLE; m_idle = 1;
                end
            end else if (m_draining && at_end && !en_i) begin
                m_data = IDLE; m_idle = 1;
            end
            if (!m_draining) m_draining = !en_i;
            else if (en_i) m_draining = 0;
            else if (at_end) m_active = 0;
            m_tick = (m_tick + 1) % FROM;
        end
    endtask

    task automatic step();
        int              p;
        logic [NREQ-1:0] exp_rdy;
        #1;
        p       = pick_next();
        exp_rdy = '0;
        if (!reset && m_active && !m_draining && (m_tick == FROM - 1) && p >= 0)
            exp_rdy[p] = 1'b1;
        chk("ready", 32'(req_ready_o), 32'(exp_rdy));
        @(posedge clk);
        model_edge();
        #1;
        chk("data",  32'(data_o),  32'(m_data));
        chk("load",  32'(load_o),  32'(m_load));
        chk("grant", 32'(grant_o), 32'(m_grant));
        chk("idle",  32'(idle_o),  32'(m_idle));
        chk("busy",  32'(busy_o),  32'(m_active));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Advance until the model's slot position reaches t (bounded).
    task automatic align(input int t);
        for (int i = 0; i < 2 * FROM && m_tick != t; i++) step();
        chk("align", 32'(m_tick), 32'(t));
    endtask

    initial begin
        steps(2);
        reset = 1'b0;
        steps(2);

        // All requesters valid: rotating grants from 0.
        req_valid_i = 4'b1111;
        req_data_i  = {4'h4, 4'h3, 4'h2, 4'h1};
        en_i = 1'b1;
        steps(21);

        // Single requester 2 wins every slot.
        req_valid_i = 4'b0100;
        req_data_i  = {4'h0, 4'hA, 4'h0, 4'h0};
        steps(12);

        // No requesters: idle fill with strobes.
        req_valid_i = 4'b0000;
        steps(12);

        // Drop enable at slot position 1 and flush to off.
        req_valid_i = 4'b1111;
        align(1);
        en_i = 1'b0;
        steps(8);

        // Reset in a load cycle with requester 1 pending.
        en_i = 1'b1;
        req_valid_i = 4'b0000;
        steps(2);
        align(3);
        req_valid_i = 4'b0010;
        req_data_i  = {4'h0, 4'h0, 4'h7, 4'h0};
        reset = 1'b1;
        step();
        reset = 1'b0;
        steps(2);

        // Requester 1 withdraws before the load cycle, requester 3 takes it.
        req_valid_i = 4'b0000;
        align(0);
        req_valid_i = 4'b0010;
        req_data_i  = {4'hD, 4'h0, 4'h5, 4'h0};
        steps(2);
        req_valid_i = 4'b1000;
        steps(6);

        // Random traffic with enable toggles and rare resets.
        for (int i = 0; i < 400; i++) begin
            req_valid_i = NREQ'($urandom);
            req_data_i  = (NREQ*FROM)'($urandom);
            if ($urandom_range(0, 19) == 0) en_i = ~en_i;
            reset = ($urandom_range(0, 99) == 0);
            step();
        end
        reset = 1'b0;
        steps(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
